// File: rtl/sccb_responder.sv
// sccb_responder: SCCB/I2C-style target that stands in for a camera sensor.
// Synchronises SIOC/SIOD, decodes START/STOP and ID/sub-address/data writes,
// drives ACK by pulling SIOD low (siod_oe=1), and presents a simple register
// file port (reg_addr/reg_wdata/reg_we/reg_rdata).
// Optional read path (TX_DATA/TX_NA) is compiled in when SCCB_RESP_READ_EN
// is defined; otherwise a read ID is treated as a mismatch.
// FSM state is visible as the internal signal 'state' for bound checkers.
module sccb_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_ID,
        ST_ACK_ID,
        ST_RX_SUB,
        ST_ACK_SUB,
        ST_RX_DATA,
        ST_ACK_DATA,
`ifdef SCCB_RESP_READ_EN
        ST_TX_DATA,
        ST_TX_NA,
`endif
        ST_IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sioc_sync;
    logic [SYNC_STAGES-1:0] siod_sync;
    logic                   sioc_d;
    logic                   siod_d;
    logic                   sioc_s;
    logic                   siod_s;
    logic                   start_det;
    logic                   stop_det;
    logic                   sioc_rise;
    logic                   sioc_fall;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [7:0]             rx_byte;
    logic                   id_match;

`ifdef SCCB_RESP_READ_EN
    logic                   rd_mode;
`else
    logic                   unused_rdata;
    assign unused_rdata = ^reg_rdata;
`endif

    // Synchronise the pads and keep a one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_d    <= 1'b1;
            siod_d    <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc_in};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod_in};
            sioc_d    <= sioc_s;
            siod_d    <= siod_s;
        end
    end

    assign sioc_s = sioc_sync[SYNC_STAGES-1];
    assign siod_s = siod_sync[SYNC_STAGES-1];

    // SIOD conditions use the previous SIOC level so a simultaneous SIOC edge
    // cannot hide a START/STOP.
    assign start_det = sioc_d &  siod_d & ~siod_s;
    assign stop_det  = sioc_d & ~siod_d &  siod_s;
    assign sioc_rise = ~sioc_d &  sioc_s;
    assign sioc_fall =  sioc_d & ~sioc_s;

    assign rx_byte  = {shreg[6:0], siod_s};
    assign id_match = (shreg[7:1] == DEVICE_ID[7:1]);

    // Protocol FSM: bits sampled on SIOC rise, SIOD drive changed on SIOC fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            siod_oe   <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
`ifdef SCCB_RESP_READ_EN
            rd_mode   <= 1'b0;
`endif
        end else begin
            reg_we <= 1'b0;
            if (start_det) begin
                state   <= ST_RX_ID;
                bit_cnt <= 4'd0;
                busy    <= 1'b1;
                siod_oe <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                busy    <= 1'b0;
                siod_oe <= 1'b0;
            end else if (sioc_rise) begin
                case (state)
                    ST_RX_ID, ST_RX_SUB, ST_RX_DATA: begin
                        if (bit_cnt < 4'd8) shreg <= rx_byte;
                        if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 4'd1;
                        // Eighth data bit: strobe the register write next cycle
                        if (state == ST_RX_DATA && bit_cnt == 4'd7) begin
                            reg_wdata <= rx_byte;
                            reg_we    <= 1'b1;
                        end
                    end
                    ST_ACK_ID, ST_ACK_SUB, ST_ACK_DATA: begin
                        if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 4'd1;
                    end
`ifdef SCCB_RESP_READ_EN
                    ST_TX_DATA: begin
                        if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 4'd1;
                    end
                    ST_TX_NA: begin
                        // SIOD high on the 9th clock is the master's NACK
                        if (siod_s) begin
                            state <= ST_IGNORE;
                        end else begin
                            reg_addr <= reg_addr + 8'd1;
                            bit_cnt  <= 4'd9;
                        end
                    end
`endif
                    default: ;
                endcase
            end else if (sioc_fall) begin
                case (state)
                    ST_RX_ID: begin
                        if (bit_cnt == 4'd8) begin
                            if (id_match && !shreg[0]) begin
                                state   <= ST_ACK_ID;
                                siod_oe <= 1'b1;
`ifdef SCCB_RESP_READ_EN
                                rd_mode <= 1'b0;
                            end else if (id_match) begin
                                state   <= ST_ACK_ID;
                                siod_oe <= 1'b1;
                                rd_mode <= 1'b1;
`endif
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_RX_SUB: begin
                        if (bit_cnt == 4'd8) begin
                            reg_addr <= shreg;
                            state    <= ST_ACK_SUB;
                            siod_oe  <= 1'b1;
                        end
                    end
                    ST_RX_DATA: begin
                        if (bit_cnt == 4'd8) begin
                            state   <= ST_ACK_DATA;
                            siod_oe <= 1'b1;
                        end
                    end
                    ST_ACK_ID: begin
                        bit_cnt <= 4'd0;
`ifdef SCCB_RESP_READ_EN
                        if (rd_mode) begin
                            state   <= ST_TX_DATA;
                            shreg   <= reg_rdata;
                            siod_oe <= ~reg_rdata[7];
                        end else begin
                            state   <= ST_RX_SUB;
                            siod_oe <= 1'b0;
                        end
`else
                        state   <= ST_RX_SUB;
                        siod_oe <= 1'b0;
`endif
                    end
                    ST_ACK_SUB: begin
                        bit_cnt <= 4'd0;
                        siod_oe <= 1'b0;
                        state   <= ST_RX_DATA;
                    end
                    ST_ACK_DATA: begin
                        bit_cnt  <= 4'd0;
                        siod_oe  <= 1'b0;
                        reg_addr <= reg_addr + 8'd1;
                        state    <= ST_RX_DATA;
                    end
`ifdef SCCB_RESP_READ_EN
                    ST_TX_DATA: begin
                        if (bit_cnt == 4'd8) begin
                            state   <= ST_TX_NA;
                            siod_oe <= 1'b0;
                        end else begin
                            siod_oe <= ~shreg[6];
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                    ST_TX_NA: begin
                        // Master ACKed: reg_addr already advanced, load next byte
                        if (bit_cnt == 4'd9) begin
                            state   <= ST_TX_DATA;
                            bit_cnt <= 4'd0;
                            shreg   <= reg_rdata;
                            siod_oe <= ~reg_rdata[7];
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
